signed_negate_seq: RTL and testbench

SIGNED_NEGATE_SEQ -- requirements
Module: signed_negate_seq

---
 rtl/signed_negate_seq.sv | 106 ++++++++++
 tb/tb_signed_negate_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_negate_seq.sv
// Chunk-serial two's-complement pass / negate / abs / neg-abs unit.
// One CHUNK-wide slice per clock, LSB first, ripple carry held in a flop.
module signed_negate_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [PW-1:0] STEP = PW'(CHUNK);
  localparam logic [WIDTH-1:0] MOST_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pos;
  logic             carry;
  logic             inv;
  logic             inv_n;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_n;
  logic [CHUNK:0]   sum;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    unique case (mode)
      2'b00: inv_n = 1'b0;
      2'b01: inv_n = 1'b1;
      2'b10: inv_n = p[WIDTH-1];
      2'b11: inv_n = ~p[WIDTH-1];
    endcase
  end

  // Conditional invert plus carry-in gives negation when inv is set.
  always_comb begin
    sum = {1'b0, opnd[pos +: CHUNK] ^ {CHUNK{inv}}}
        + {{CHUNK{1'b0}}, carry};
    work_n = work;
    work_n[pos +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pos   <= '0;
      carry <= 1'b0;
      inv   <= 1'b0;
      opnd  <= '0;
      work  <= '0;
      out   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            opnd  <= p;
            inv   <= inv_n;
            carry <= inv_n;
            cnt   <= '0;
            pos   <= '0;
            work  <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work  <= work_n;
          carry <= sum[CHUNK];
          cnt   <= cnt + ONE;
          pos   <= pos + STEP;
          if (cnt == LAST) begin
            state <= DONE;
            out   <= work_n;
            ovf   <= inv && (opnd == MOST_NEG);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_negate_seq.sv
// Randomised and directed bench for signed_negate_seq.
// Checks against an integer-arithmetic model of pass/neg/abs/nabs.
module tb_signed_negate_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start16 = 1'b0;
  logic [1:0]  mode16 = 2'b00;
  logic [15:0] p16 = '0;
  logic [15:0] out16;
  logic        busy16, done16, ovf16;

  logic        start8 = 1'b0;
  logic [1:0]  mode8 = 2'b00;
  logic [7:0]  p8 = '0;
  logic [7:0]  out8;
  logic        busy8, done8, ovf8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  signed_negate_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16),
    .p(p16), .out(out16), .busy(busy16), .done(done16),
    .ovf(ovf16)
  );

  signed_negate_seq #(.WIDTH(8), .CHUNK(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8),
    .p(p8), .out(out8), .busy(busy8), .done(done8),
    .ovf(ovf8)
  );

  // True signed result, then wrapped to w bits.
  function automatic void model(input int w, input longint pv,
                                input logic [1:0] m,
                                output longint o, output bit ov);
    longint full, half, v, r;
    full = longint'(1) << w;
    half = full / 2;
    v = (pv >= half) ? pv - full : pv;
    case (m)
      2'd0: r = v;
      2'd1: r = -v;
      2'd2: r = (v < 0) ? -v : v;
      default: r = (v < 0) ? v : -v;
    endcase
    ov = (r >= half) || (r < -half);
    o = (r < 0) ? r + full : r;
  endfunction

  // Drives one 16-bit operation; lat counts negedges from start to done.
  task automatic do_op16(input logic [15:0] pv, input logic [1:0] m,
                         output int lat, output logic [15:0] o,
                         output logic ov, output bit ok);
    logic [15:0] pre;
    @(negedge clk);
    p16 = pv;
    mode16 = m;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    pre = out16;
    lat = 1;
    ok = 1'b1;
    while (!done16 && lat < 50) begin
      if (!busy16 || out16 !== pre) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy16) ok = 1'b0;
    o = out16;
    ov = ovf16;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start16 = 1'b1;
    p16 = 16'h8000;
    mode16 = 2'b01;
    repeat (3) @(negedge clk);
    total++;
    if ({out16, ovf16, busy16, done16} !== 19'd0) begin
      bad++;
      $display("FAIL reset16: out=%h ovf=%b busy=%b done=%b want 0",
               out16, ovf16, busy16, done16);
    end
    total++;
    if ({out8, ovf8, busy8, done8} !== 11'd0) begin
      bad++;
      $display("FAIL reset8: out=%h ovf=%b busy=%b done=%b want 0",
               out8, ovf8, busy8, done8);
    end
    rst = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic test_directed;
    logic [15:0] dp [14] = '{16'h0005, 16'hFFFF, 16'h8000, 16'h7FFF,
                             16'h0003, 16'hFFF0, 16'h1234, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h8000,
                             16'h8000, 16'h8000};
    logic [1:0] dm [14] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0,
                            2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0};
    int lat;
    logic [15:0] o;
    logic ov;
    bit ok;
    longint eo;
    bit eov;
    for (int i = 0; i < 14; i++) begin
      do_op16(dp[i], dm[i], lat, o, ov, ok);
      model(16, longint'(dp[i]), dm[i], eo, eov);
      total++;
      if (o !== eo[15:0] || ov !== eov) begin
        bad++;
        $display("FAIL dir%0d p=%h m=%0d: got %h/%b want %h/%b",
                 i, dp[i], dm[i], o, ov, eo[15:0], eov);
      end
      total++;
      if (lat !== 5 || !ok) begin
        bad++;
        $display("FAIL dir%0d timing: lat=%0d ok=%b want 5/1",
                 i, lat, ok);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] corner [4] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
    logic [15:0] pv;
    logic [1:0] m;
    int lat;
    logic [15:0] o;
    logic ov;
    bit ok;
    longint eo;
    bit eov;
    for (int i = 0; i < 40; i++) begin
      pv = 16'($urandom);
      if ($urandom_range(3) == 0) pv = corner[$urandom_range(3)];
      m = 2'($urandom_range(3));
      do_op16(pv, m, lat, o, ov, ok);
      model(16, longint'(pv), m, eo, eov);
      total++;
      if (o !== eo[15:0] || ov !== eov || lat !== 5 || !ok) begin
        bad++;
        $display("FAIL rnd%0d p=%h m=%0d: got %h/%b lat=%0d ok=%b want %h/%b lat=5",
                 i, pv, m, o, ov, lat, ok, eo[15:0], eov);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    logic [15:0] o;
    logic ov;
    bit ok;
    int dn;
    bit held;
    logic [15:0] first;
    do_op16(16'h0011, 2'd0, lat, o, ov, ok);
    @(negedge clk);
    p16 = 16'h0123;
    mode16 = 2'd1;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    start16 = 1'b1;
    p16 = 16'h4444;
    mode16 = 2'd0;
    @(negedge clk);
    start16 = 1'b0;
    p16 = 16'hABCD;
    mode16 = 2'd2;
    dn = 0;
    held = 1'b1;
    first = '0;
    for (int i = 0; i < 20; i++) begin
      if (done16) begin
        dn++;
        if (dn == 1) first = out16;
      end else if (dn == 0 && out16 !== 16'h0011) begin
        held = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (first !== 16'hFEDD || dn !== 1 || !held) begin
      bad++;
      $display("FAIL ignore_start: out=%h dones=%0d held=%b want FEDD/1/1",
               first, dn, held);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [15:0] o;
    logic ov;
    bit ok;
    int dn;
    @(negedge clk);
    p16 = 16'h1234;
    mode16 = 2'd1;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({out16, ovf16, busy16, done16} !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid: out=%h ovf=%b busy=%b done=%b want 0",
               out16, ovf16, busy16, done16);
    end
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done16) dn++;
    end
    total++;
    if (dn !== 0 || out16 !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_nodone: dones=%0d out=%h want 0/0000",
               dn, out16);
    end
    do_op16(16'h0042, 2'd1, lat, o, ov, ok);
    total++;
    if (o !== 16'hFFBE || ov !== 1'b0 || lat !== 5 || !ok) begin
      bad++;
      $display("FAIL reset_mid_restart: got %h/%b lat=%0d want FFBE/0 lat=5",
               o, ov, lat);
    end
  endtask

  task automatic test_narrow;
    int lat;
    @(negedge clk);
    p8 = 8'h01;
    mode8 = 2'd1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (out8 !== 8'hFF || ovf8 !== 1'b0 || lat !== 9) begin
      bad++;
      $display("FAIL narrow: out=%h ovf=%b lat=%0d want FF/0 lat=9",
               out8, ovf8, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pa;
    logic [7:0] pb;
    logic [1:0] ma;
    logic [1:0] mb;
    longint ea, eb;
    bit eova, eovb;
    int dn, i1, i2;
    logic [7:0] o1, o2;
    pa = 8'($urandom);
    pb = 8'($urandom);
    ma = 2'($urandom_range(3));
    mb = 2'($urandom_range(3));
    model(8, longint'(pa), ma, ea, eova);
    model(8, longint'(pb), mb, eb, eovb);
    @(negedge clk);
    p8 = pa;
    mode8 = ma;
    start8 = 1'b1;
    dn = 0;
    i1 = -1;
    i2 = -1;
    o1 = '0;
    o2 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start8) start8 = 1'b0;
      if (done8) begin
        dn++;
        if (dn == 1) begin
          i1 = i;
          o1 = out8;
          p8 = pb;
          mode8 = mb;
          start8 = 1'b1;
        end else if (dn == 2) begin
          i2 = i;
          o2 = out8;
        end
      end
    end
    total++;
    if (o1 !== ea[7:0] || o2 !== eb[7:0] || dn !== 2 || i2 - i1 !== 9) begin
      bad++;
      $display("FAIL back_to_back: o1=%h o2=%h dones=%0d gap=%0d want %h %h 2 9",
               o1, o2, dn, i2 - i1, ea[7:0], eb[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_narrow();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
